serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq.sv | 119 +++++++++++
 tb/tb_serial_add_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial add/subtract built around a single full adder.
// One operand bit is processed per clock, LSB first; subtraction is done as
// a + ~b + 1 by preloading the carry with op. Results are registered at the
// end of the run and held until the next operation completes.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   r_sh;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt;
   logic               last_bit;
   logic               fa_sum;
   logic               fa_carry;

   // The only adder in the block; fed from the operand shift registers
   full_adder u_fa (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .cin   (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: DONE lasts exactly one cycle, start only honoured in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from the state
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         r_sh    <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= op ? ~b : b;
                  carry_q <= op;
                  cnt     <= '0;
               end
            end
            RUN: begin
               a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
               r_sh    <= {fa_sum, r_sh[WIDTH-1:1]};
               carry_q <= fa_carry;
               cnt     <= cnt + CNT_W'(1);
               if (last_bit) begin
                  // carry_q here is the carry into the MSB
                  result <= {fa_sum, r_sh[WIDTH-1:1]};
                  cout   <= fa_carry;
                  ovf    <= fa_carry ^ carry_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks for serial_add_seq at WIDTH=8.

module tb_serial_add_seq;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         busy;
   logic         done;

   int total;
   int bad;
   int cyc;

   serial_add_seq #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result),
      .cout   (cout),
      .ovf    (ovf),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         c;
      logic         v;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Reference arithmetic: true sum/difference and sign-rule overflow
   task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic c, output logic v);
      int unsigned t;
      if (!o) begin
         t = int'(x) + int'(y);
         c = (t > 255);
      end else begin
         t = (int'(x) - int'(y)) & 32'h1FF;
         c = (x >= y);
      end
      r = t[W-1:0];
      if (!o) v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      else    v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
   endtask

   // Run one operation; optionally poke a fresh start at bit cycle 'poke'.
   // Checks latency, busy, result stability during RUN and single done pulse.
   task automatic run_op(input string name, input logic o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er,
                         input logic ec, input logic ev, input int poke, input bit quiet);
      int n;
      logic [W-1:0] held;
      bit held_ok;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      if (!quiet) check({name, "_busy_after_start"}, busy, 1);
      held = result; held_ok = 1; n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (start) begin start = 1'b0; a = '0; b = '0; end
         if (n == poke) begin start = 1'b1; op = 1'b0; a = 8'hFF; b = 8'hFF; end
         if (done) break;
         if (result !== held) held_ok = 0;
      end
      start = 1'b0;
      if (!quiet) begin
         check({name, "_latency"}, n, W);
         check({name, "_busy_in_done"}, busy, 0);
         check({name, "_held"}, held_ok, 1);
      end
      check({name, "_result"}, result, er);
      check({name, "_cout"}, cout, ec);
      check({name, "_ovf"}, ovf, ev);
      @(negedge clk);
      if (!quiet) check({name, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      logic [W-1:0] er;
      logic ec, ev;
      int t0, t1, t2, n;
      total = 0; bad = 0; cyc = 0;
      start = 0; op = 0; a = 0; b = 0;

      vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};

      // Reset state
      rst_n = 0;
      #1;
      check("rst_result", result, 0);
      check("rst_flags", {cout, ovf, busy, done}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      // Directed table
      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].r, vecs[i].c, vecs[i].v, -1, 0);

      // Start during RUN is ignored, no second operation follows
      run_op("ignore", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3, 0);
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy || done) n++;
      end
      check("ignore_no_queue", n, 0);

      // Reset mid-run: outputs cleared at once, no done pulse
      @(negedge clk);
      start = 1; op = 0; a = 8'h55; b = 8'h0A;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("midrst_result", result, 0);
      check("midrst_flags", {cout, ovf, busy, done}, 0);
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) n++;
      end
      check("midrst_no_done", n, 0);
      rst_n = 1;
      run_op("after_rst", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, -1, 0);

      // Start held high: back-to-back operations
      @(negedge clk);
      start = 1; op = 0; a = 8'h10; b = 8'h20;
      t0 = 0; t1 = 0; t2 = 0;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!done && n < 40) begin @(negedge clk); n++; end
         check($sformatf("b2b%0d_seen", k), done, 1);
         if (k == 0) begin
            t0 = cyc;
            check("b2b0_result", {cout, ovf, result}, {2'b00, 8'h30});
            op = 1; a = 8'h03; b = 8'h09;
         end else if (k == 1) begin
            t1 = cyc;
            check("b2b1_result", {cout, ovf, result}, {2'b00, 8'hFA});
            op = 0; a = 8'h7F; b = 8'h7F;
         end else begin
            t2 = cyc;
            check("b2b2_result", {cout, ovf, result}, {2'b01, 8'hFE});
         end
         @(negedge clk);
      end
      start = 0;
      check("b2b_gap1", t1 - t0, W + 2);
      check("b2b_gap2", t2 - t1, W + 2);
      repeat (3) @(negedge clk);

      // Random self-check against reference arithmetic
      for (int i = 0; i < 1000; i++) begin
         logic o;
         logic [W-1:0] x, y;
         o = 1'($urandom_range(1));
         x = 8'($urandom);
         y = 8'($urandom);
         model(o, x, y, er, ec, ev);
         run_op($sformatf("rnd%0d", i), o, x, y, er, ec, ev, -1, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
